bram_16384x1: RTL and testbench

- True dual-port synchronous block RAM, 16384 words x 1 bit.
- Two independent read/write ports share one clock.
- Used as the leaf bank of the ESP unisim SRAM wrappers. Wrappers tile these banks, 32 deep x 8 wide, to build 2^19 x 8 memories.
- Port 0 is normally the write port and port 1 the read port. Both ports support both operations.

---
 rtl/bram_pkg.sv | 17 +
 rtl/bram_port.sv | 82 ++++++++
 rtl/bram_16384x1.sv | 119 +++++++++++
 tb/tb_bram_16384x1.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared geometry and simulation-check settings for the 16384x1 leaf RAM bank.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package bram_pkg;

    // Address width; the array depth is derived from it so the two never drift.
    localparam int ADDR_W = 14;
    // Data width, which is also the per-bit write-mask width.
    localparam int DATA_W = 1;
    localparam int DEPTH  = 1 << ADDR_W;

    // Same-address collision check (simulation only). When enabled, any cycle
    // where both ports are enabled on the same address with at least one of
    // them writing stops the simulation with "address conflict".
    localparam bit COLL_CHK_EN = 1'b1;

endpackage : bram_pkg

// File: rtl/bram_port.sv
// One access port of the dual-port RAM: enable decode, masked-write request, registered read.
// Latency: read data appears on q one clock after the edge that sampled the address.
// Backpressure: none; every enabled cycle is accepted, q holds while the port is disabled.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset (clears q only)
//   ce, we, wem      port enable, write enable, per-bit write mask
//   a, d             address and write data presented by the user
//   rd_dat           current array contents at rd_addr, supplied by the top level
//   rd_addr          address the top level must look up for this port
//   wr_addr, wr_dat  write address/data handed to the shared array write process
//   wr_mask          effective write mask (zero when no write happens this cycle)
//   wr_act           this port performs a write this cycle
//   port_en          this port is enabled this cycle
//   q                registered read data
module bram_port
    import bram_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          we,
    input  logic [DW-1:0] wem,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] rd_dat,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_dat,
    output logic [DW-1:0] wr_mask,
    output logic          wr_act,
    output logic          port_en,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_d;
    logic [DW-1:0] q_q;
    logic          en;
    logic          wr;

    // Enable decode. Written as if-tests so an unknown CE/WE in simulation
    // falls through to the inactive default instead of propagating X.
    always_comb begin
        en = 1'b0;
        wr = 1'b0;
        if (ce) begin
            en = 1'b1;
            if (we) begin
                wr = 1'b1;
            end
        end
    end

    // Read-first: q captures the array contents before this edge's write
    // lands, because rd_dat is the pre-edge value of the array.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = rd_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign rd_addr = a;
    assign wr_addr = a;
    assign wr_dat  = d;
    assign wr_mask = wr ? wem : '0;
    assign wr_act  = wr;
    assign port_en = en;
    assign q       = q_q;

endmodule : bram_port

// File: rtl/bram_16384x1.sv
// True dual-port synchronous RAM, 16384 x 1, single clock, read-first on both ports.
// Latency: 1 clock from address sample to Q0/Q1.
// Backpressure: none; both ports accept an access every enabled cycle.
//
// Ports:
//   CLK, RSTN                 shared clock; async active-low reset clears Q0/Q1, not the array
//   CE0, A0, D0, WE0, WEM0    port 0 enable, address, data, write enable, bit mask
//   Q0                        port 0 registered read data
//   CE1, A1, D1, WE1, WEM1    port 1 enable, address, data, write enable, bit mask
//   Q1                        port 1 registered read data
module bram_16384x1
    import bram_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int DATA_W_P = DATA_W,
    parameter bit COLL_CHK = COLL_CHK_EN
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                CE0,
    input  logic [ADDR_W_P-1:0] A0,
    input  logic [DATA_W_P-1:0] D0,
    input  logic                WE0,
    input  logic [DATA_W_P-1:0] WEM0,
    output logic [DATA_W_P-1:0] Q0,
    input  logic                CE1,
    input  logic [ADDR_W_P-1:0] A1,
    input  logic [DATA_W_P-1:0] D1,
    input  logic                WE1,
    input  logic [DATA_W_P-1:0] WEM1,
    output logic [DATA_W_P-1:0] Q1
);

    localparam int DEPTH_P = 1 << ADDR_W_P;

    // Zero contents at time zero; reset never touches the array.
    logic [DATA_W_P-1:0] mem [DEPTH_P] = '{default: '0};

    logic [ADDR_W_P-1:0] rd_addr0, rd_addr1;
    logic [ADDR_W_P-1:0] wr_addr0, wr_addr1;
    logic [DATA_W_P-1:0] wr_dat0,  wr_dat1;
    logic [DATA_W_P-1:0] wr_mask0, wr_mask1;
    logic [DATA_W_P-1:0] rd_dat0,  rd_dat1;
    logic                wr_act0,  wr_act1;
    logic                en0,      en1;
    logic                coll;

    assign rd_dat0 = mem[rd_addr0];
    assign rd_dat1 = mem[rd_addr1];

    bram_port #(
        .AW (ADDR_W_P),
        .DW (DATA_W_P)
    ) u_port0 (
        .clk     (CLK),
        .rst_n   (RSTN),
        .ce      (CE0),
        .we      (WE0),
        .wem     (WEM0),
        .a       (A0),
        .d       (D0),
        .rd_dat  (rd_dat0),
        .rd_addr (rd_addr0),
        .wr_addr (wr_addr0),
        .wr_dat  (wr_dat0),
        .wr_mask (wr_mask0),
        .wr_act  (wr_act0),
        .port_en (en0),
        .q       (Q0)
    );

    bram_port #(
        .AW (ADDR_W_P),
        .DW (DATA_W_P)
    ) u_port1 (
        .clk     (CLK),
        .rst_n   (RSTN),
        .ce      (CE1),
        .we      (WE1),
        .wem     (WEM1),
        .a       (A1),
        .d       (D1),
        .rd_dat  (rd_dat1),
        .rd_addr (rd_addr1),
        .wr_addr (wr_addr1),
        .wr_dat  (wr_dat1),
        .wr_mask (wr_mask1),
        .wr_act  (wr_act1),
        .port_en (en1),
        .q       (Q1)
    );

    // Both ports write from this single process. Port 1's assignments come
    // second, so on an overlapping mask bit at the same address port 1 wins,
    // while non-overlapping bits from both ports all land.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DATA_W_P; i++) begin
            if (wr_mask0[i]) begin
                mem[wr_addr0][i] <= wr_dat0[i];
            end
        end
        for (int i = 0; i < DATA_W_P; i++) begin
            if (wr_mask1[i]) begin
                mem[wr_addr1][i] <= wr_dat1[i];
            end
        end
    end

    assign coll = en0 && en1 && (wr_act0 || wr_act1) && (rd_addr0 == rd_addr1);

    // Simulation-only guard against same-address collisions; synthesis
    // ignores the assertion.
    always_ff @(posedge CLK) begin
        if (COLL_CHK) begin
            assert (!coll) else $fatal(1, "address conflict");
        end
    end

endmodule : bram_16384x1

// File: tb/tb_bram_16384x1.sv
module tb_bram_16384x1;

    logic        CLK;
    logic        RSTN;
    logic        CE0, WE0, CE1, WE1;
    logic [13:0] A0, A1;
    logic [0:0]  D0, WEM0, D1, WEM1;
    logic [0:0]  Q0, Q1;

    int n_assert = 0;
    int n_fail   = 0;

    // Collision semantics are exercised here, so the stopping check is off.
    bram_16384x1 #(
        .COLL_CHK (1'b0)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .CE0  (CE0),
        .A0   (A0),
        .D0   (D0),
        .WE0  (WE0),
        .WEM0 (WEM0),
        .Q0   (Q0),
        .CE1  (CE1),
        .A1   (A1),
        .D1   (D1),
        .WE1  (WE1),
        .WEM1 (WEM1),
        .Q1   (Q1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [0:0] obs, input logic [0:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        CE0 = 1'b0; WE0 = 1'b0; A0 = '0; D0 = '0; WEM0 = '0;
        CE1 = 1'b0; WE1 = 1'b0; A1 = '0; D1 = '0; WEM1 = '0;
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic p0(input logic ce, input logic we, input logic [13:0] a,
                      input logic d, input logic m);
        CE0 = ce; WE0 = we; A0 = a; D0 = d; WEM0 = m;
    endtask

    task automatic p1(input logic ce, input logic we, input logic [13:0] a,
                      input logic d, input logic m);
        CE1 = ce; WE1 = we; A1 = a; D1 = d; WEM1 = m;
    endtask

    initial begin
        idle();
        RSTN = 1'b1;
        #1 RSTN = 1'b0;
        #1;
        check("reset_q0", Q0, 1'b0);
        check("reset_q1", Q1, 1'b0);
        @(negedge CLK);
        RSTN = 1'b1;

        // Preload address 5 with 1.
        p0(1, 1, 14'd5, 1, 1); tick(); idle();

        // Basic write at top address, then read it and address 0 on port 1.
        p0(1, 1, 14'h3FFF, 1, 1); tick(); idle();
        p1(1, 0, 14'h3FFF, 0, 0); tick();
        check("basic_rd_3fff", Q1, 1'b1);
        p1(1, 0, 14'h0000, 0, 0); tick();
        check("basic_rd_0000", Q1, 1'b0);

        // Both Q outputs at 1, then reset away from any clock edge.
        p0(1, 0, 14'h3FFF, 0, 0); p1(1, 0, 14'd5, 0, 0); tick(); idle();
        check("pre_reset_q0", Q0, 1'b1);
        check("pre_reset_q1", Q1, 1'b1);
        #2 RSTN = 1'b0;
        #1;
        check("async_reset_q0", Q0, 1'b0);
        check("async_reset_q1", Q1, 1'b0);
        #1 RSTN = 1'b1;
        p1(1, 0, 14'd5, 0, 0); tick(); idle();
        check("contents_kept_5", Q1, 1'b1);

        // Write with mask bit clear leaves address 10 at 0.
        p0(1, 1, 14'd10, 1, 0); tick(); idle();
        p1(1, 0, 14'd10, 0, 0); tick();
        check("mask0_rd_10", Q1, 1'b0);
        p1(1, 0, 14'd5, 0, 0); tick();
        check("rd_5_again", Q1, 1'b1);
        // WE0=0 is only a read.
        p0(1, 0, 14'd10, 1, 1); tick(); idle();
        p1(1, 0, 14'd10, 0, 0); tick();
        check("we0_low_rd_10", Q1, 1'b0);
        // CE1=0 on a would-be read of 1 holds Q1.
        p1(0, 0, 14'd5, 0, 0); tick();
        check("ce1_low_hold", Q1, 1'b0);
        // X on CE0 must not write.
        idle();
        CE0 = 1'bx; WE0 = 1'b1; A0 = 14'd70; D0 = 1'b1; WEM0 = 1'b1;
        tick(); idle();
        p1(1, 0, 14'd70, 0, 0); tick(); idle();
        check("ce_x_no_write", Q1, 1'b0);

        // Read-first on the same port.
        p0(1, 0, 14'h3FFF, 0, 0); tick();
        check("rf_q0_setup", Q0, 1'b1);
        p0(1, 1, 14'd7, 1, 1); tick();
        check("rf_old_data_7", Q0, 1'b0);
        p0(1, 0, 14'd7, 0, 0); tick(); idle();
        check("rf_new_data_7", Q0, 1'b1);

        // Concurrent writes on different addresses.
        p0(1, 1, 14'd100, 1, 1); p1(1, 1, 14'd200, 1, 1); tick();
        check("conc_wr_q0_old", Q0, 1'b0);
        p0(1, 0, 14'd200, 0, 0); p1(1, 0, 14'd100, 0, 0); tick(); idle();
        check("conc_rd_200", Q0, 1'b1);
        check("conc_rd_100", Q1, 1'b1);

        // Cross-port read-during-write: port 0 sees old data.
        p0(1, 0, 14'd50, 0, 0); p1(1, 1, 14'd50, 1, 1); tick(); idle();
        check("coll_rd_old_50", Q0, 1'b0);
        p0(1, 0, 14'd50, 0, 0); tick(); idle();
        check("coll_rd_new_50", Q0, 1'b1);

        // Both ports write, overlapping mask: port 1 wins.
        p0(1, 1, 14'd60, 0, 1); p1(1, 1, 14'd60, 1, 1); tick(); idle();
        p1(1, 0, 14'd60, 0, 0); tick(); idle();
        check("dual_wr_p1_wins_1", Q1, 1'b1);
        p0(1, 1, 14'd61, 1, 1); tick(); idle();
        p0(1, 1, 14'd61, 1, 1); p1(1, 1, 14'd61, 0, 1); tick(); idle();
        p0(1, 0, 14'd61, 0, 0); tick(); idle();
        check("dual_wr_p1_wins_0", Q0, 1'b0);
        // Port 1 masked off: port 0's bit lands.
        p0(1, 1, 14'd62, 1, 1); p1(1, 1, 14'd62, 0, 0); tick(); idle();
        p1(1, 0, 14'd62, 0, 0); tick(); idle();
        check("dual_wr_p1_masked", Q1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_bram_16384x1
